// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: power-on release p_reset_n -> clk_enb -> s_reset_n, plus soft reboot.
// Soft reboot (synchronizer, SOFT_RST/SOFT_CLKOFF, boot_cnt) is built only with RST_SEQ_SOFT_REBOOT_EN.
module rst_seq_ctrl #(
    parameter int unsigned P_RST_CYC = 16,
    parameter int unsigned CLK_WAIT  = 8,
    parameter int unsigned S_RST_CYC = 8
) (
    input  logic       clk,
    input  logic       e_reset_n,
    input  logic       soft_boot_req,
    output logic       p_reset_n,
    output logic       clk_enb,
    output logic       s_reset_n,
    output logic [3:0] boot_cnt,
    output logic       seq_busy
);

    typedef enum logic [2:0] {
        StPrst,
        StClkWait,
        StSrst,
        StRun,
        StSoftRst,
        StSoftClkOff
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_s;
    logic       boot_inc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
        boot_inc = 1'b0;
        unique case (state_q)
            StPrst: begin
                if (cnt_q == 8'd0) begin
                    state_d = StClkWait;
                    cnt_d   = 8'(CLK_WAIT - 1);
                end
            end
            StClkWait: begin
                if (cnt_q == 8'd0) begin
                    state_d = StSrst;
                    cnt_d   = 8'(S_RST_CYC - 1);
                end
            end
            StSrst: begin
                if (cnt_q == 8'd0) begin
                    state_d = StRun;
                    cnt_d   = 8'd0;
                end
            end
            StRun: begin
                if (req_s) begin
                    state_d  = StSoftRst;
                    cnt_d    = 8'(S_RST_CYC - 1);
                    boot_inc = 1'b1;
                end
            end
            StSoftRst: begin
                if (cnt_q == 8'd0) begin
                    state_d = StSoftClkOff;
                    cnt_d   = 8'(CLK_WAIT - 1);
                end
            end
            StSoftClkOff: begin
                if (cnt_q == 8'd0) begin
                    state_d = StSrst;
                    cnt_d   = 8'(S_RST_CYC - 1);
                end
            end
            default: begin
                state_d = StPrst;
                cnt_d   = 8'(P_RST_CYC - 1);
            end
        endcase
    end

    // Reset acts as the PRST entry, so the counter is preloaded and PRST lasts P_RST_CYC cycles.
    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            state_q   <= StPrst;
            cnt_q     <= 8'(P_RST_CYC - 1);
            p_reset_n <= 1'b0;
            clk_enb   <= 1'b0;
            s_reset_n <= 1'b0;
            seq_busy  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_reset_n <= (state_d != StPrst);
            clk_enb   <= (state_d == StSrst) || (state_d == StRun) || (state_d == StSoftRst);
            s_reset_n <= (state_d == StRun);
            seq_busy  <= (state_d != StRun);
        end
    end

`ifdef RST_SEQ_SOFT_REBOOT_EN
    logic [1:0] sync_q;
    logic [3:0] boot_cnt_q;

    // Held clear while the core is in soft reset so a stale request cannot retrigger.
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            sync_q <= 2'b00;
        end else if (!s_reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], soft_boot_req};
        end
    end

    assign req_s = sync_q[1];

    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            boot_cnt_q <= 4'd0;
        end else if (boot_inc && (boot_cnt_q != 4'hf)) begin
            boot_cnt_q <= boot_cnt_q + 4'd1;
        end
    end

    assign boot_cnt = boot_cnt_q;
`else
    logic unused_soft_boot;

    assign req_s            = 1'b0;
    assign boot_cnt         = 4'd0;
    assign unused_soft_boot = soft_boot_req ^ boot_inc;
`endif

endmodule
